id_remap_table_v2: RTL
======================

Name: id_remap_table_v2

Overview:
Parametrised next-generation ID remapper for the reorder buffer. It maps each incoming original transaction ID to a unique remapped ID {row, col} and stores the original ID, then restores it when the response returns. All outstanding requests that share an original ID go to one row, which preserves per-ID ordering. Compared with the previous generation it has:
- independent row and column depth;
- separate in and out ID widths;
- valid/ready handshakes;
- per-row free-slot bitmaps, so frees within a row may arrive out of order;
- a registered restore response;
- illegal-free detection.

Parameters:
- IN_ID_WIDTH, 4, width of the original ID.
- NUM_ROWS, 4, number of rows (distinct original IDs in flight); must be ≥2.
- NUM_COLS, 4, slots per row (outstanding requests per original ID); must be ≥2.
- OUT_ID_WIDTH, 4, width of the remapped ID; must be ≥ ROW_W+COL_W, where ROW_W=$clog2(NUM_ROWS) and COL_W=$clog2(NUM_COLS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- alloc_valid  in  1  allocation request.
- alloc_orig_id  in  IN_ID_WIDTH  original ID to remap.
- alloc_ready  out  1  allocation accepted when alloc_valid && alloc_ready.
- alloc_unique_id  out  OUT_ID_WIDTH  remapped ID {zero pad, row, col}; valid while alloc_ready.
- free_valid  in  1  free request; always accepted.
- free_unique_id  in  OUT_ID_WIDTH  remapped ID being retired.
- free_rsp_valid  out  1  one-cycle pulse carrying the restored ID.
- free_rsp_orig_id  out  IN_ID_WIDTH  restored original ID.
- occupancy  out  $clog2(NUM_ROWS*NUM_COLS+1)  total slots in use.
- full  out  1  occupancy == NUM_ROWS*NUM_COLS.
- err_illegal_free  out  1  sticky flag: a free targeted an unallocated slot.

Behaviour:
- Reset (async assert, sync-safe deassert): all rows unbound, all bitmaps clear, occupancy=0, alloc_ready=0 until the first clock after deassert, free_rsp_valid=0, free_rsp_orig_id=0, err_illegal_free=0. A reset mid-operation discards every outstanding mapping.
- Row state: bound flag, bound original ID, used-slot bitmap [NUM_COLS].
- Row select:
  - On a hit (a bound row whose stored ID equals alloc_orig_id), the hit row is used.
  - Otherwise the lowest-index unbound row is used.
  - At most one row can hit.
- Column select: lowest clear bit in the chosen row's bitmap.
- alloc_ready = (hit && hit row not full) || (!hit && an unbound row exists).
  - A hit on a full row stalls; the request never spills to another row, so ordering is preserved.
  - alloc_ready and alloc_unique_id are combinational from current state and alloc_orig_id. alloc_ready does not depend on a same-cycle free.
- On an accepted alloc at a clock edge:
  - set the bitmap bit;
  - store alloc_orig_id in the slot;
  - bind the row if it was unbound;
  - occupancy +1.
- On a free:
  - decode the row and column from the low ROW_W+COL_W bits; upper bits are ignored.
  - If the slot bit is set: clear it, occupancy −1, and next cycle pulse free_rsp_valid with the stored original ID.
  - If the row's bitmap becomes all-zero, unbind the row.
  - Latency is one cycle. Back-to-back frees give back-to-back responses.
- Illegal free (slot bit clear, or row index ≥ NUM_ROWS): no state change, free_rsp_valid stays 0, err_illegal_free is set and holds until reset.
- Simultaneous alloc and free in the same cycle:
  - Both take effect; occupancy is unchanged.
  - If the free empties row R and the alloc hits R in the same cycle, R stays bound with the new slot set.
  - A freed slot is not reusable until the next cycle.
- Slot storage is not cleared on free.

Optional Feature:
- Macro ID_REMAP_STATS_EN.
- When defined, adds two outputs, both cleared by reset:
  - stat_stall_cnt (32 bits): increments on each cycle with alloc_valid && !alloc_ready, saturating at all-ones.
  - stat_peak_occ (occupancy width): holds the maximum occupancy seen.
- When undefined, neither port nor its logic exists and behaviour is otherwise identical.

Test Plan:
- Reset then alloc orig 0x3 four times (defaults) -> unique IDs 0x0, 0x1, 0x2, 0x3; fifth alloc of 0x3 sees alloc_ready=0; occupancy=4, full=0.
- Alloc 0x3, 0x5, 0x3 -> 0x0, 0x4, 0x1; free 0x4 -> next cycle free_rsp_valid=1, free_rsp_orig_id=0x5; row 1 unbound; a following alloc of 0x9 -> 0x4.
- Out-of-order free within a row: alloc 0x7 ×3 (0x0, 0x1, 0x2), free 0x1 -> rsp 0x7; next alloc 0x7 -> 0x1 (lowest free column).
- Fill all 16 slots with orig 0..3 -> full=1, alloc_ready=0 for any ID; free 0x0 and alloc orig 0x0 in the same cycle -> that alloc still sees alloc_ready=0; next cycle alloc 0x0 returns 0x0 with occupancy 16.
- Single outstanding 0x2 at slot 0x8: free 0x8 and alloc 0x2 in the same cycle -> alloc returns 0x9, row 2 stays bound, occupancy stays 1, rsp 0x2.
- Free 0xC when nothing is allocated -> err_illegal_free=1 and sticky, no rsp, occupancy 0; assert rst_n low mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/id_remap_table_v2.sv
// Remaps original IDs to unique {row, col} IDs and restores them when the response returns; one row per in-flight original ID.
// Latency: alloc grant and unique ID are combinational; the free response is registered (one cycle).
// Backpressure: alloc_ready drops when the hit row is full or no unbound row exists; frees are always accepted.
// Optional statistics outputs are enabled by defining ID_REMAP_STATS_EN.
module id_remap_table_v2 #(
  parameter int IN_ID_WIDTH  = 4,
  parameter int NUM_ROWS     = 4,
  parameter int NUM_COLS     = 4,
  parameter int OUT_ID_WIDTH = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     alloc_valid,
  input  logic [IN_ID_WIDTH-1:0]                   alloc_orig_id,
  output logic                                     alloc_ready,
  output logic [OUT_ID_WIDTH-1:0]                  alloc_unique_id,
  input  logic                                     free_valid,
  input  logic [OUT_ID_WIDTH-1:0]                  free_unique_id,
  output logic                                     free_rsp_valid,
  output logic [IN_ID_WIDTH-1:0]                   free_rsp_orig_id,
  output logic [$clog2(NUM_ROWS*NUM_COLS+1)-1:0]   occupancy,
  output logic                                     full,
  output logic                                     err_illegal_free
`ifdef ID_REMAP_STATS_EN
  ,
  output logic [31:0]                              stat_stall_cnt,
  output logic [$clog2(NUM_ROWS*NUM_COLS+1)-1:0]   stat_peak_occ
`endif
);

  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int COL_W = $clog2(NUM_COLS);
  localparam int OCC_W = $clog2(NUM_ROWS*NUM_COLS+1);

  // Row state: binding, bound original ID, used-slot bitmap; per-slot stored original ID.
  logic [NUM_ROWS-1:0]    bound;
  logic [IN_ID_WIDTH-1:0] row_id  [NUM_ROWS];
  logic [NUM_COLS-1:0]    bitmap  [NUM_ROWS];
  logic [IN_ID_WIDTH-1:0] slot_id [NUM_ROWS][NUM_COLS];
  logic                   ready_en;

  logic                   any_hit, any_unbound, sel_row_full;
  logic [ROW_W-1:0]       hit_row, unb_row, sel_row;
  logic [COL_W-1:0]       sel_col;
  logic [NUM_COLS-1:0]    sel_bits;
  logic                   alloc_fire;

  logic [ROW_W-1:0]       free_row;
  logic [COL_W-1:0]       free_col;
  logic                   free_legal, free_ok;
  logic [IN_ID_WIDTH-1:0] free_data;

  logic [NUM_COLS-1:0]    bitmap_nxt [NUM_ROWS];
  logic [OCC_W-1:0]       occ_nxt;

  // Row select (hit first, else lowest unbound row) and lowest free column in that row.
  always_comb begin
    any_hit      = 1'b0;
    any_unbound  = 1'b0;
    hit_row      = '0;
    unb_row      = '0;
    sel_col      = '0;
    sel_row_full = 1'b1;
    for (int r = NUM_ROWS-1; r >= 0; r--) begin
      if (bound[r] && (row_id[r] == alloc_orig_id)) begin
        any_hit = 1'b1;
        hit_row = ROW_W'(r);
      end
      if (!bound[r]) begin
        any_unbound = 1'b1;
        unb_row     = ROW_W'(r);
      end
    end
    sel_row  = any_hit ? hit_row : unb_row;
    sel_bits = bitmap[sel_row];
    for (int c = NUM_COLS-1; c >= 0; c--) begin
      if (!sel_bits[c]) begin
        sel_col      = COL_W'(c);
        sel_row_full = 1'b0;
      end
    end
  end

  // A hit on a full row stalls rather than spilling, which keeps per-ID ordering.
  assign alloc_ready     = ready_en && (any_hit ? !sel_row_full : any_unbound);
  assign alloc_unique_id = OUT_ID_WIDTH'({sel_row, sel_col});
  assign alloc_fire      = alloc_valid && alloc_ready;

  assign free_row = free_unique_id[COL_W +: ROW_W];
  assign free_col = free_unique_id[COL_W-1:0];

  // Free is legal only for an existing row whose addressed slot is in use; also fetch the stored ID.
  always_comb begin
    free_legal = 1'b0;
    free_data  = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if ((free_row == ROW_W'(r)) && (free_col == COL_W'(c)) && bitmap[r][c]) begin
          free_legal = 1'b1;
          free_data  = slot_id[r][c];
        end
      end
    end
  end

  assign free_ok = free_valid && free_legal;

  // Next bitmaps and occupancy; the alloc sees the pre-free bitmap, so a freed slot is not reused this cycle.
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      bitmap_nxt[r] = bitmap[r];
      if (free_ok && (free_row == ROW_W'(r)))
        bitmap_nxt[r] = bitmap_nxt[r] & ~(NUM_COLS'(1) << free_col);
      if (alloc_fire && (sel_row == ROW_W'(r)))
        bitmap_nxt[r] = bitmap_nxt[r] | (NUM_COLS'(1) << sel_col);
    end
    occ_nxt = occupancy;
    case ({alloc_fire, free_ok})
      2'b10:   occ_nxt = occupancy + OCC_W'(1);
      2'b01:   occ_nxt = occupancy - OCC_W'(1);
      default: occ_nxt = occupancy;
    endcase
  end

  // Control state: bitmaps, row bindings, occupancy, registered free response, sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en         <= 1'b0;
      bound            <= '0;
      occupancy        <= '0;
      free_rsp_valid   <= 1'b0;
      free_rsp_orig_id <= '0;
      err_illegal_free <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        bitmap[r] <= '0;
        row_id[r] <= '0;
      end
    end else begin
      ready_en  <= 1'b1;
      occupancy <= occ_nxt;
      for (int r = 0; r < NUM_ROWS; r++) begin
        bitmap[r] <= bitmap_nxt[r];
        bound[r]  <= |bitmap_nxt[r];
      end
      if (alloc_fire && !any_hit)
        row_id[sel_row] <= alloc_orig_id;
      free_rsp_valid <= free_ok;
      if (free_ok)
        free_rsp_orig_id <= free_data;
      if (free_valid && !free_legal)
        err_illegal_free <= 1'b1;
    end
  end

  // Slot payload storage; stale contents are harmless because the bitmap gates every read.
  always_ff @(posedge clk) begin
    if (alloc_fire)
      slot_id[sel_row][sel_col] <= alloc_orig_id;
  end

  assign full = (occupancy == OCC_W'(NUM_ROWS*NUM_COLS));

`ifdef ID_REMAP_STATS_EN
  // Saturating stall counter and peak-occupancy tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_cnt <= '0;
      stat_peak_occ  <= '0;
    end else begin
      if (alloc_valid && !alloc_ready && !(&stat_stall_cnt))
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      if (occ_nxt > stat_peak_occ)
        stat_peak_occ <= occ_nxt;
    end
  end
`endif

endmodule
